// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU operand/result bus, writeback strobe and debug
// read port of the ALU issue sequencer, bundled for use as a module port.
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [XLEN-1:0] alu_rd;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  // Sequencer side
  modport slave (
    input  instr_valid, instr, alu_rd, dbg_addr,
    output instr_ready, alu_op, alu_rs1, alu_rs2,
           wb_valid, wb_addr, wb_data, illegal, dbg_data
  );

  // Instruction source / ALU / debug side
  modport master (
    output instr_valid, instr, alu_rd, dbg_addr,
    input  instr_ready, alu_op, alu_rs1, alu_rs2,
           wb_valid, wb_addr, wb_data, illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue.sv
// Front-end sequencer for the registered 32-bit ALU: decodes RV32I OP and
// OP-IMM words, reads operands from a 32x32 register file, drives the ALU
// for one cycle and writes the ALU result back. One instruction per 3 cycles.
module alu_issue #(
  parameter int XLEN          = 32,
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      dest_q, dest_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] rf_q [32];

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_idx, rs2_idx;
  logic            dec_legal;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_rs1, dec_rs2;
  logic            accept;
  logic            rf_we;

  assign funct3  = bus.instr[14:12];
  assign funct7  = bus.instr[31:25];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];

  // Decode the presented word into ALU op, operands and legality
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'b0000;
    dec_rs1   = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
    dec_rs2   = '0;
    case (bus.instr[6:0])
      OPC_OP: begin
        dec_op    = {bus.instr[30], funct3};
        dec_rs2   = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
        dec_legal = !STRICT_DECODE || (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001) begin
          // SLLI: instr[30] never selects an alternate op
          dec_op    = 4'b0001;
          dec_rs2   = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
          dec_legal = !STRICT_DECODE || (funct7 == F7_ZERO);
        end else if (funct3 == 3'b101) begin
          // SRLI/SRAI: shift amount is the raw shamt, not the sign-extended imm
          dec_op    = {bus.instr[30], 3'b101};
          dec_rs2   = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
          dec_legal = !STRICT_DECODE || (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        end else begin
          // Immediate ops never reach SUB, so the top op bit is forced to 0
          dec_op    = {1'b0, funct3};
          dec_rs2   = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
          dec_legal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign accept = bus.instr_valid && (state_q == IDLE);
  assign rf_we  = (state_q == WB) && (dest_q != 5'd0);

  // Sequencer next-state and registered ALU drive
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    dest_d    = dest_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            op_d    = dec_op;
            rs1_d   = dec_rs1;
            rs2_d   = dec_rs2;
            dest_d  = bus.instr[11:7];
            state_d = EXEC;
          end else begin
            // Illegal words are consumed with a one-cycle flag and no side effects
            illegal_d = 1'b1;
          end
        end
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and ALU drive registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      dest_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file: cleared by reset, written at the end of WB except for x0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[dest_q] <= bus.alu_rd;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.alu_op      = op_q;
  assign bus.alu_rs1     = rs1_q;
  assign bus.alu_rs2     = rs2_q;
  assign bus.illegal     = illegal_q;
  assign bus.wb_valid    = (state_q == WB);
  assign bus.wb_addr     = dest_q;
  assign bus.wb_data     = bus.alu_rd;
  assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? '0 : rf_q[bus.dbg_addr];

endmodule

// File: doc/alu_issue.md
Name:
alu_issue

Overview:
- Front-end sequencer that drives the team's registered 32-bit ALU: it is the initiator side of the ALU's `op`/`rs1`/`rs2` -> `rd` interface.
- Accepts RV32I OP and OP-IMM instruction words over a valid/ready handshake and decodes them into the ALU 4-bit op code.
- Owns a 32x32 register file: reads operands, drives the ALU, captures `rd` after the ALU's one-cycle latency, writes back.
- Sits between the fetch/stimulus source and the ALU instance. A debug read port exposes register contents.

Parameters:
- XLEN, 32, datapath width. Must equal the ALU width; only 32 is supported.
- STRICT_DECODE, 1, when 1, unsupported funct7 values raise `illegal`; when 0, only `instr[30]` is consulted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset. The ALU instance shares this line.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  block can accept an instruction.
- instr  in  32  RV32I instruction word.
- alu_op  out  4  ALU op code, registered.
- alu_rs1  out  32  ALU operand 1, registered.
- alu_rs2  out  32  ALU operand 2, registered.
- alu_rd  in  32  registered ALU result.
- wb_valid  out  1  writeback strobe.
- wb_addr  out  5  destination register index.
- wb_data  out  32  writeback data.
- illegal  out  1  one-cycle pulse: undecodable instruction was consumed.
- dbg_addr  in  5  debug register index.
- dbg_data  out  32  combinational read of rf[dbg_addr]; returns 0 for index 0.

Behaviour:
- Reset (synchronous): state=IDLE; rf[0..31]=0; alu_op=0; alu_rs1=0; alu_rs2=0; dest=0; illegal=0; wb_valid=0. Reset overrides every other event.
- FSM states: IDLE, EXEC, WB.
- instr_ready=1 only in IDLE. An instruction is accepted on a rising edge only when instr_valid & instr_ready. `instr` may change freely while ready is low.
- Accept edge E0, legal instruction: register alu_op, alu_rs1=rf[rs1], alu_rs2, dest=instr[11:7]; IDLE->EXEC.
- EXEC (E0..E1): ALU operands stable; the ALU registers its result at E1; EXEC->WB unconditionally.
- WB (E1..E2): wb_valid=1, wb_addr=dest, wb_data=alu_rd (combinational from alu_rd). At E2, rf[dest]=alu_rd unless dest=0; WB->IDLE.
- Latency: accept at E0 -> wb_valid during cycle after E1 -> new value readable at E2. Throughput is 1 instruction per 3 cycles, so no data hazards exist.
- Reads see rf state before the edge. Index 0 always reads 0, including debug reads.
- Decode, opcode 0110011 (R-type):
  - alu_op={instr[30],funct3}; alu_rs2=rf[rs2].
  - STRICT: funct7 must be 0000000, or 0100000 with funct3 in {000,101}; anything else is illegal.
- Decode, opcode 0010011 (I-type):
  - funct3 001/101: shift. alu_rs2={27'b0,instr[24:20]}; alu_op={instr[30],funct3} for 101, {0,001} for 001. STRICT: funct7 must be 0000000 (or 0100000 for 101).
  - Other funct3: alu_op={0,funct3}; alu_rs2=sign-extended instr[31:20].
  - Op 1000 (SUB) is unreachable from I-type.
- Any other opcode is illegal.
- Illegal accept at E0: illegal=1 for exactly the cycle E0..E1. State stays IDLE, so instr_ready stays 1 and a new accept is possible at E1. ALU outputs and rf are unchanged, and no wb_valid is generated.
- Writeback to x0: wb_valid is still asserted with wb_addr=0; rf is not written.
- Reset during EXEC or WB: the instruction is abandoned, with no rf write. If reset is high at E2, no write occurs.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093): alu_op=0000, alu_rs1=0, alu_rs2=5 in EXEC; wb_valid=1, wb_addr=1, wb_data=5 in the cycle after E1; dbg_addr=1 -> 5 after E2.
- Then ADDI x2,x0,-3 (0xFFD00113), then SUB x3,x1,x2 (0x402081B3): alu_op=1000, alu_rs1=5, alu_rs2=0xFFFFFFFD; wb_data=8; dbg x3=8.
- SRAI x4,x2,1 (0x40115213): alu_op=1101, alu_rs2=1 (not sign-extended imm); wb_data=0xFFFFFFFE.
- ADDI x0,x0,7 (0x00700013): wb_valid=1, wb_addr=0; dbg x0 stays 0. Hold instr_valid=1 throughout: instr_ready is low in EXEC and WB, and exactly one accept occurs per 3 cycles.
- LW 0x00002083, then R-type 0x4020C1B3 (funct7 0100000 with XOR): each gives a single-cycle illegal=1, no wb_valid, instr_ready stays 1, alu_* unchanged. With STRICT_DECODE=0 the second decodes as op 1100 -> default result 0 is written to x3.
- ADDI x5,x0,9 (0x00900293), with reset asserted during the WB cycle: no rf write; dbg x5=0; instr_ready=1 on the first cycle after reset deasserts.
